scsi_io_arbiter: RTL and testbench

//  Shares the single host sector channel (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between two SCSI target instances.

---
 rtl/scsi_io_arbiter_if.sv | 35 +++
 rtl/scsi_io_arbiter.sv | 150 +++++++++++++++
 tb/tb_scsi_io_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scsi_io_arbiter_if.sv
// Signal bundle between the two SCSI targets, the arbiter and the host sector channel.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface scsi_io_arbiter_if;
    logic [1:0]  io_rd;
    logic [1:0]  io_wr;
    logic [31:0] io_lba0;
    logic [31:0] io_lba1;
    logic [1:0]  io_ack;
    logic [15:0] buff_din0;
    logic [15:0] buff_din1;
    logic [1:0]  buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic        grant;
    logic        active;
    logic        timeout;

    modport master (
        input  io_rd, io_wr, io_lba0, io_lba1, buff_din0, buff_din1,
        input  sd_ack, sd_buff_wr,
        output io_ack, buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din,
        output grant, active, timeout
    );

    modport slave (
        output io_rd, io_wr, io_lba0, io_lba1, buff_din0, buff_din1,
        output sd_ack, sd_buff_wr,
        input  io_ack, buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  grant, active, timeout
    );
endinterface

// File: rtl/scsi_io_arbiter.sv
// Round-robin arbiter sharing one host sector channel between two SCSI targets:
// forwards the granted target's request/LBA and steers ack and buffer traffic to it.
module scsi_io_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic                      clk,
    input  logic                      reset,
    scsi_io_arbiter_if.master         bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_next_q, rr_next_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic [23:0] wait_cnt_q, wait_cnt_d;
    logic        abort_q, abort_d;

    logic [1:0]  pend_s;
    logic        pick_s;
    logic [1:0]  io_ack_s;
    logic [1:0]  buff_wr_s;
    logic [15:0] sd_buff_din_s;

    // A zero TIMEOUT means wait for the host forever.
    function automatic logic issue_expired(input logic [23:0] cnt);
        return (TIMEOUT != 24'd0) && (cnt == (TIMEOUT - 24'd1));
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_next_q  <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            sd_lba_q   <= 32'h0000_0000;
            wait_cnt_q <= 24'd0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_next_q  <= rr_next_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            sd_lba_q   <= sd_lba_d;
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_next_d  = rr_next_q;
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        sd_lba_d   = sd_lba_q;
        wait_cnt_d = wait_cnt_q;
        abort_d    = 1'b0;
        pend_s     = bus.io_rd | bus.io_wr;
        pick_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_s != 2'b00) begin
                    if (pend_s == 2'b11) begin
                        pick_s = rr_next_q;
                    end else begin
                        pick_s = pend_s[1];
                    end
                    // A target asserting both rd and wr is treated as a read.
                    grant_d    = pick_s;
                    sd_lba_d   = pick_s ? bus.io_lba1 : bus.io_lba0;
                    sd_rd_d    = bus.io_rd[pick_s];
                    sd_wr_d    = ~bus.io_rd[pick_s];
                    wait_cnt_d = 24'd0;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_XFER;
                end else if (issue_expired(wait_cnt_q)) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 24'd1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_XFER: begin
                if (!bus.sd_ack) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                rr_next_d = ~grant_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ack and buffer steering toward the granted target only.
    always_comb begin
        io_ack_s      = 2'b00;
        buff_wr_s     = 2'b00;
        sd_buff_din_s = 16'h0000;
        if (state_q == ST_XFER) begin
            io_ack_s[grant_q]  = bus.sd_ack;
            buff_wr_s[grant_q] = bus.sd_buff_wr;
            sd_buff_din_s      = grant_q ? bus.buff_din1 : bus.buff_din0;
        end else begin
            // abort_q is only ever set during the DONE cycle after a timeout.
            io_ack_s[grant_q]  = abort_q;
        end
    end

    assign bus.io_ack      = io_ack_s;
    assign bus.buff_wr     = buff_wr_s;
    assign bus.sd_buff_din = sd_buff_din_s;
    assign bus.sd_lba      = sd_lba_q;
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign bus.grant       = grant_q;
    assign bus.active      = (state_q != ST_IDLE);
    assign bus.timeout     = abort_q;

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Self-checking bench for scsi_io_arbiter: directed vector table, hand-written
// timeout/reset/alternation sequences and a randomized run against a reference model.
module tb_scsi_io_arbiter;

    localparam logic [23:0] TMO  = 24'd16;
    localparam logic [31:0] LBA0 = 32'h0000_1234;
    localparam logic [31:0] LBA1 = 32'h0000_5678;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scsi_io_arbiter_if bus ();

    scsi_io_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction-level view) ----------------
    bit          m_busy, m_issuing, m_streaming, m_settling, m_abort;
    bit          m_owner, m_rr, m_is_read;
    logic [31:0] m_lba;
    int          m_waited;

    task automatic model_reset();
        m_busy = 0; m_issuing = 0; m_streaming = 0; m_settling = 0; m_abort = 0;
        m_owner = 0; m_rr = 0; m_is_read = 0; m_lba = 32'h0; m_waited = 0;
    endtask

    task automatic model_check(input string tag);
        logic [1:0]  sel;
        logic [1:0]  e_ack, e_bwr;
        logic [15:0] e_din;
        sel   = m_owner ? 2'b10 : 2'b01;
        e_ack = m_streaming ? (bus.sd_ack ? sel : 2'b00) : (m_abort ? sel : 2'b00);
        e_bwr = (m_streaming && bus.sd_buff_wr) ? sel : 2'b00;
        e_din = m_streaming ? (m_owner ? bus.buff_din1 : bus.buff_din0) : 16'h0000;
        chk({tag, ".active"},  32'(bus.active),      32'(m_busy));
        chk({tag, ".grant"},   32'(bus.grant),       32'(m_owner));
        chk({tag, ".sd_rd"},   32'(bus.sd_rd),       32'(m_issuing && m_is_read));
        chk({tag, ".sd_wr"},   32'(bus.sd_wr),       32'(m_issuing && !m_is_read));
        chk({tag, ".sd_lba"},  bus.sd_lba,           m_lba);
        chk({tag, ".io_ack"},  32'(bus.io_ack),      32'(e_ack));
        chk({tag, ".buff_wr"}, 32'(bus.buff_wr),     32'(e_bwr));
        chk({tag, ".din"},     32'(bus.sd_buff_din), 32'(e_din));
        chk({tag, ".timeout"}, 32'(bus.timeout),     32'(m_abort));
    endtask

    task automatic model_step();
        logic [1:0] pend;
        m_abort = 0;
        if (!m_busy) begin
            pend = bus.io_rd | bus.io_wr;
            if (pend != 2'b00) begin
                m_owner   = (pend == 2'b11) ? m_rr : pend[1];
                m_is_read = bus.io_rd[m_owner];
                m_lba     = m_owner ? bus.io_lba1 : bus.io_lba0;
                m_busy    = 1; m_issuing = 1; m_waited = 0;
            end
        end else if (m_issuing) begin
            if (bus.sd_ack) begin
                m_issuing = 0; m_streaming = 1;
            end else if (m_waited + 1 == int'(TMO)) begin
                m_issuing = 0; m_settling = 1; m_abort = 1;
            end else begin
                m_waited++;
            end
        end else if (m_streaming) begin
            if (!bus.sd_ack) begin
                m_streaming = 0; m_settling = 1;
            end
        end else if (m_settling) begin
            m_settling = 0; m_busy = 0; m_rr = ~m_owner;
        end
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic cycle(input string tag);
        #1;
        model_check(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.io_rd = 2'b00; bus.io_wr = 2'b00;
        bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        ack;
        logic        bwr;
        logic        e_rd;
        logic        e_wr;
        logic [1:0]  e_ack;
        logic [1:0]  e_bwr;
        logic [15:0] e_din;
        logic        e_grant;
        logic        e_active;
        logic [31:0] e_lba;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int n_rd, n_tmo, n_ack, got;
        bit seen;
        int ack_bias, req_bias;

        reset = 1'b1;
        clear_inputs();
        bus.io_lba0 = LBA0; bus.io_lba1 = LBA1;
        bus.buff_din0 = 16'hAAAA; bus.buff_din1 = 16'hBEEF;

        //                 rd     wr     ack   bwr   e_rd  e_wr  e_ack  e_bwr  e_din     gnt   act   lba
        tbl[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, LBA0};
        tbl[2]  = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, LBA0};
        tbl[3]  = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 16'hAAAA, 1'b0, 1'b1, LBA0};
        tbl[4]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'hAAAA, 1'b0, 1'b1, LBA0};
        tbl[5]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'hAAAA, 1'b0, 1'b1, LBA0};
        tbl[6]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, LBA0};
        tbl[7]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, LBA0};
        tbl[8]  = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, LBA1};
        tbl[9]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, LBA1};
        tbl[10] = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 16'hBEEF, 1'b1, 1'b1, LBA1};
        tbl[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'hBEEF, 1'b1, 1'b1, LBA1};
        tbl[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, LBA1};
        tbl[13] = '{2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, LBA1};
        tbl[14] = '{2'b01, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, LBA0};
        tbl[15] = '{2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 16'hAAAA, 1'b0, 1'b1, LBA0};
        tbl[16] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'hAAAA, 1'b0, 1'b1, LBA0};
        tbl[17] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, LBA0};
        tbl[18] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, LBA0};
        tbl[19] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, LBA1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sd_rd",   32'(bus.sd_rd),       32'd0);
        chk("rst.sd_wr",   32'(bus.sd_wr),       32'd0);
        chk("rst.sd_lba",  bus.sd_lba,           32'd0);
        chk("rst.io_ack",  32'(bus.io_ack),      32'd0);
        chk("rst.buff_wr", 32'(bus.buff_wr),     32'd0);
        chk("rst.grant",   32'(bus.grant),       32'd0);
        chk("rst.active",  32'(bus.active),      32'd0);
        chk("rst.timeout", 32'(bus.timeout),     32'd0);
        chk("rst.din",     32'(bus.sd_buff_din), 32'd0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 20; i++) begin
            bus.io_rd = tbl[i].rd; bus.io_wr = tbl[i].wr;
            bus.sd_ack = tbl[i].ack; bus.sd_buff_wr = tbl[i].bwr;
            #1;
            chk($sformatf("tbl%0d.sd_rd", i),   32'(bus.sd_rd),       32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d.sd_wr", i),   32'(bus.sd_wr),       32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d.io_ack", i),  32'(bus.io_ack),      32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d.buff_wr", i), 32'(bus.buff_wr),     32'(tbl[i].e_bwr));
            chk($sformatf("tbl%0d.din", i),     32'(bus.sd_buff_din), 32'(tbl[i].e_din));
            chk($sformatf("tbl%0d.grant", i),   32'(bus.grant),       32'(tbl[i].e_grant));
            chk($sformatf("tbl%0d.active", i),  32'(bus.active),      32'(tbl[i].e_active));
            chk($sformatf("tbl%0d.sd_lba", i),  bus.sd_lba,           tbl[i].e_lba);
            @(posedge clk);
            #1;
        end

        // Timeout: sd_rd held for TMO ISSUE cycles, then 1-cycle ack/timeout pulse
        do_reset();
        bus.io_lba0 = 32'hABCD_0000;
        bus.io_rd = 2'b01;
        n_rd = 0; n_tmo = 0; n_ack = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.sd_rd) n_rd++;
            if (bus.timeout) n_tmo++;
            if (bus.io_ack == 2'b01) begin
                n_ack++;
                chk("tmo.pulse_align", 32'(bus.timeout), 32'd1);
                bus.io_rd = 2'b00;
            end
        end
        chk("tmo.rd_cycles",  32'(n_rd),  32'(TMO));
        chk("tmo.pulses",     32'(n_tmo), 32'd1);
        chk("tmo.ack_pulses", 32'(n_ack), 32'd1);
        chk("tmo.idle_after", 32'(bus.active), 32'd0);
        // Subsequent request served normally
        bus.io_wr = 2'b10;
        @(posedge clk);
        #1;
        chk("tmo.next_wr",    32'(bus.sd_wr), 32'd1);
        chk("tmo.next_grant", 32'(bus.grant), 32'd1);
        chk("tmo.next_lba",   bus.sd_lba,     LBA1);
        bus.sd_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("tmo.next_ack", 32'(bus.io_ack), 32'd2);
        chk("tmo.next_tmo", 32'(bus.timeout), 32'd0);
        bus.sd_ack = 1'b0; bus.io_wr = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Async reset while in XFER, then target 1 write after release
        bus.io_lba0 = LBA0;
        bus.io_rd = 2'b01;
        @(posedge clk);
        #1;
        bus.sd_ack = 1'b1; bus.sd_buff_wr = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.pre_ack", 32'(bus.io_ack), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.io_ack",  32'(bus.io_ack),      32'd0);
        chk("arst.buff_wr", 32'(bus.buff_wr),     32'd0);
        chk("arst.din",     32'(bus.sd_buff_din), 32'd0);
        chk("arst.active",  32'(bus.active),      32'd0);
        chk("arst.lba",     bus.sd_lba,           32'd0);
        chk("arst.rdwr",    32'({bus.sd_rd, bus.sd_wr}), 32'd0);
        clear_inputs();
        bus.io_wr = 2'b10;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.grant", 32'(bus.grant), 32'd1);
        chk("arst.sd_wr", 32'(bus.sd_wr), 32'd1);
        chk("arst.sd_rd", 32'(bus.sd_rd), 32'd0);

        // Simultaneous requests alternate 0,1,0,1
        do_reset();
        bus.io_rd = 2'b11;
        for (int t = 0; t < 4; t++) begin
            seen = 0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (bus.sd_rd) seen = 1;
            end
            chk($sformatf("rr%0d.issued", t), 32'(seen), 32'd1);
            got = int'(bus.grant);
            chk($sformatf("rr%0d.grant", t), 32'(got), 32'(t % 2));
            chk($sformatf("rr%0d.lba", t), bus.sd_lba, (t % 2 == 1) ? LBA1 : LBA0);
            bus.sd_ack = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            bus.sd_ack = 1'b0;
        end
        clear_inputs();

        // Randomized run against the reference model
        do_reset();
        model_reset();
        ack_bias = 4; req_bias = 4;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                ack_bias = int'($urandom_range(1, 7));
                req_bias = int'($urandom_range(1, 7));
            end
            bus.io_rd      = {($urandom_range(0, 7) < req_bias), ($urandom_range(0, 7) < req_bias)};
            bus.io_wr      = {($urandom_range(0, 7) < req_bias), ($urandom_range(0, 7) < req_bias)};
            bus.io_lba0    = $urandom;
            bus.io_lba1    = $urandom;
            bus.buff_din0  = 16'($urandom);
            bus.buff_din1  = 16'($urandom);
            bus.sd_ack     = ($urandom_range(0, 7) < ack_bias);
            bus.sd_buff_wr = 1'($urandom);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
